// File: rtl/serial_frame_buffer.sv
// Bit-serial pixel receiver that packs MSB-first pixels into a two-bank ping-pong
// frame store, with a random-access registered read port on the released bank.
module serial_frame_buffer #(
  parameter int PIXEL_BITS   = 1,
  parameter int FRAME_PIXELS = 784,
  parameter int ADDR_W       = 10,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixel_bit,
  input  logic                  pixel_bit_valid,
  output logic                  pixel_bit_ready,
  input  logic                  frame_sync,
  output logic                  frame_ready,
  input  logic                  frame_release,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [PIXEL_BITS-1:0] rd_data,
  output logic                  rd_bank,
  output logic [CNT_W-1:0]      frames_accepted,
  output logic                  sync_drop
);

  localparam int BIT_W     = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam int MEM_DEPTH = 2 * FRAME_PIXELS;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PIXEL_BITS - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W + 1)'(FRAME_PIXELS);
  localparam logic [MEM_AW-1:0] BANK1_OFS = MEM_AW'(FRAME_PIXELS);

  typedef enum logic [0:0] {ST_FILL, ST_STALL} state_t;

  state_t                  state_reg;
  logic [1:0]              full_reg;
  logic [1:0]              full_next;
  logic                    wbank_reg;
  logic                    rd_bank_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [ADDR_W-1:0]       pix_cnt_reg;
  logic [CNT_W-1:0]        frames_reg;
  logic                    sync_drop_reg;
  logic [PIXEL_BITS-1:0]   rd_data_reg;
  logic [PIXEL_BITS-1:0]   wr_pixel;
  logic [PIXEL_BITS-1:0]   mem [MEM_DEPTH];

  logic                    sync_eff;
  logic                    accept;
  logic                    bit_last;
  logic                    pix_last;
  logic                    wr_en;
  logic                    frame_done;
  logic                    rel_eff;
  logic                    rd_in_range;
  logic [MEM_AW-1:0]       wr_idx;
  logic [MEM_AW-1:0]       rd_idx;

  // A bank being written is never full, so readiness depends only on the write bank flag.
  assign pixel_bit_ready = ~full_reg[wbank_reg];
  assign sync_eff        = frame_sync & pixel_bit_ready;
  assign accept          = pixel_bit_valid & pixel_bit_ready & ~frame_sync;
  assign bit_last        = (bit_cnt_reg == BIT_LAST);
  assign pix_last        = (pix_cnt_reg == PIX_LAST);
  assign wr_en           = accept & bit_last;
  assign frame_done      = wr_en & pix_last;
  assign rel_eff         = frame_release & full_reg[rd_bank_reg];

  assign wr_idx      = wbank_reg ? (BANK1_OFS + MEM_AW'(pix_cnt_reg)) : MEM_AW'(pix_cnt_reg);
  assign rd_idx      = rd_bank_reg ? (BANK1_OFS + MEM_AW'(rd_addr)) : MEM_AW'(rd_addr);
  assign rd_in_range = ({1'b0, rd_addr} < FRAME_LIM);

  assign frame_ready     = full_reg[rd_bank_reg];
  assign rd_data         = rd_data_reg;
  assign rd_bank         = rd_bank_reg;
  assign frames_accepted = frames_reg;
  assign sync_drop       = sync_drop_reg;

  // Release is applied first so a completion onto the same bank leaves it full.
  always_comb begin
    full_next = full_reg;
    if (rel_eff) begin
      full_next[rd_bank_reg] = 1'b0;
    end
    if (frame_done) begin
      full_next[wbank_reg] = 1'b1;
    end
  end

  generate
    if (PIXEL_BITS == 1) begin : g_direct
      assign wr_pixel = pixel_bit;
    end else begin : g_shift
      logic [PIXEL_BITS-2:0] sh_reg;
      assign wr_pixel = {sh_reg, pixel_bit};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_reg <= '0;
        end else if (accept) begin
          sh_reg <= wr_pixel[PIXEL_BITS-2:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      full_reg      <= 2'b00;
      wbank_reg     <= 1'b0;
      rd_bank_reg   <= 1'b0;
      bit_cnt_reg   <= '0;
      pix_cnt_reg   <= '0;
      frames_reg    <= '0;
      sync_drop_reg <= 1'b0;
    end else begin
      full_reg      <= full_next;
      sync_drop_reg <= sync_eff & ((pix_cnt_reg != '0) | (bit_cnt_reg != '0));

      if (rel_eff) begin
        rd_bank_reg <= ~rd_bank_reg;
      end

      if (sync_eff) begin
        bit_cnt_reg <= '0;
        pix_cnt_reg <= '0;
      end else if (accept) begin
        if (bit_last) begin
          bit_cnt_reg <= '0;
          if (pix_last) begin
            pix_cnt_reg <= '0;
            wbank_reg   <= ~wbank_reg;
            frames_reg  <= frames_reg + 1'b1;
          end else begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end

      if (frame_done) begin
        state_reg <= full_next[~wbank_reg] ? ST_STALL : ST_FILL;
      end else if ((state_reg == ST_STALL) && !full_reg[wbank_reg]) begin
        state_reg <= ST_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_in_range) begin
      rd_data_reg <= mem[rd_idx];
    end else begin
      rd_data_reg <= '0;
    end
  end

endmodule

// File: tb/tb_serial_frame_buffer.sv
// Scoreboard bench: a 1-bit/784-pixel instance and an 8-bit/4-pixel instance.
module tb_serial_frame_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       bit_a = 0, valid_a = 0, sync_a = 0, rel_a = 0;
  logic [9:0] addr_a = '0;
  logic       rdy_a, frdy_a, bank_a, drop_a;
  logic [0:0] data_a;
  logic [15:0] frames_a;

  logic       bit_b = 0, valid_b = 0, sync_b = 0, rel_b = 0;
  logic [2:0] addr_b = '0;
  logic       rdy_b, frdy_b, bank_b, drop_b;
  logic [7:0] data_b;
  logic [15:0] frames_b;

  serial_frame_buffer #(.PIXEL_BITS(1), .FRAME_PIXELS(784), .ADDR_W(10), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .pixel_bit(bit_a), .pixel_bit_valid(valid_a),
    .pixel_bit_ready(rdy_a), .frame_sync(sync_a), .frame_ready(frdy_a),
    .frame_release(rel_a), .rd_addr(addr_a), .rd_data(data_a), .rd_bank(bank_a),
    .frames_accepted(frames_a), .sync_drop(drop_a));

  serial_frame_buffer #(.PIXEL_BITS(8), .FRAME_PIXELS(4), .ADDR_W(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .pixel_bit(bit_b), .pixel_bit_valid(valid_b),
    .pixel_bit_ready(rdy_b), .frame_sync(sync_b), .frame_ready(frdy_b),
    .frame_release(rel_b), .rd_addr(addr_b), .rd_data(data_b), .rd_bank(bank_b),
    .frames_accepted(frames_b), .sync_drop(drop_b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    exp;
    string name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic req_a = 0, req_b = 0, req_a_d = 0, req_b_d = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: a read issued before an edge is compared on the following falling edge.
  always @(posedge clk) begin
    req_a_d <= req_a;
    req_b_d <= req_b;
  end

  always @(negedge clk) begin
    exp_t e;
    if (req_a_d) begin
      if (q_a.size() == 0) check("sb_a_underflow", 1, 0);
      else begin
        e = q_a.pop_front();
        check(e.name, int'(data_a), e.exp);
      end
    end
    if (req_b_d) begin
      if (q_b.size() == 0) check("sb_b_underflow", 1, 0);
      else begin
        e = q_b.pop_front();
        check(e.name, int'(data_b), e.exp);
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic send_a(input logic b);
    int t = 0;
    while (!rdy_a && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("a_ready_timeout", 0, 1);
    valid_a = 1'b1; bit_a = b;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic b);
    int t = 0;
    while (!rdy_b && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("b_ready_timeout", 0, 1);
    valid_b = 1'b1; bit_b = b;
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) send_b(v[k]);
  endtask

  task automatic read_a(input int addr, input int exp);
    exp_t e;
    e.exp = exp; e.name = $sformatf("a_rd[%0d]", addr);
    q_a.push_back(e);
    addr_a = 10'(addr); req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
  endtask

  task automatic read_b(input int addr, input int exp);
    exp_t e;
    e.exp = exp; e.name = $sformatf("b_rd[%0d]", addr);
    q_b.push_back(e);
    addr_b = 3'(addr); req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
  endtask

  task automatic release_a();
    rel_a = 1'b1; @(negedge clk); rel_a = 1'b0;
  endtask

  task automatic release_b();
    rel_b = 1'b1; @(negedge clk); rel_b = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of both instances
    check("a_rst_ready", int'(rdy_a), 1);
    check("a_rst_frame_ready", int'(frdy_a), 0);
    check("a_rst_rd_data", int'(data_a), 0);
    check("a_rst_rd_bank", int'(bank_a), 0);
    check("a_rst_frames", int'(frames_a), 0);
    check("a_rst_sync_drop", int'(drop_a), 0);
    check("b_rst_ready", int'(rdy_b), 1);
    check("b_rst_frame_ready", int'(frdy_b), 0);
    check("b_rst_frames", int'(frames_b), 0);

    // Sync with nothing received must not report a drop
    sync_b = 1'b1; @(negedge clk); sync_b = 1'b0;
    check("b_sync_idle_nodrop", int'(drop_b), 0);

    // Three stray bits, then sync with a bit presented that must be dropped
    send_b(1); send_b(1); send_b(1);
    sync_b = 1'b1; valid_b = 1'b1; bit_b = 1'b1;
    @(negedge clk);
    sync_b = 1'b0; valid_b = 1'b0;
    check("b_sync_drop_pulse", int'(drop_b), 1);
    @(negedge clk);
    check("b_sync_drop_once", int'(drop_b), 0);

    send_byte_b(8'hA5); send_byte_b(8'h3C); send_byte_b(8'hFF); send_byte_b(8'h00);
    check("b_frame_ready", int'(frdy_b), 1);
    check("b_frames_1", int'(frames_b), 1);
    read_b(0, 8'hA5); read_b(1, 8'h3C); read_b(2, 8'hFF); read_b(3, 8'h00);
    read_b(5, 0);

    send_byte_b(8'h12); send_byte_b(8'h34); send_byte_b(8'h56); send_byte_b(8'h78);
    check("b_frames_2", int'(frames_b), 2);
    check("b_stall_ready", int'(rdy_b), 0);
    release_b();
    check("b_rel_rd_bank", int'(bank_b), 1);
    check("b_rel_ready", int'(rdy_b), 1);
    check("b_rel_frame_ready", int'(frdy_b), 1);
    read_b(0, 8'h12); read_b(3, 8'h78);
    release_b();
    check("b_rel2_frame_ready", int'(frdy_b), 0);
    check("b_rel2_rd_bank", int'(bank_b), 0);
    release_b();
    check("b_rel_idle_ignored", int'(bank_b), 0);
    @(negedge clk);

    // 1-bit frame, pixel i = (i%8==0)
    do_reset();
    for (int i = 0; i < 783; i++) send_a((i % 8) == 0);
    check("a_not_ready_before_last", int'(frdy_a), 0);
    send_a(0);
    check("a_frame_ready", int'(frdy_a), 1);
    check("a_frames_1", int'(frames_a), 1);
    read_a(0, 1); read_a(1, 0); read_a(8, 1); read_a(776, 1); read_a(783, 0); read_a(800, 0);

    // Second frame fills bank 1 then stalls
    for (int i = 0; i < 784; i++) send_a((i % 3) == 0);
    check("a_frames_2", int'(frames_a), 2);
    bad = 0;
    repeat (20) begin
      if (rdy_a) bad++;
      @(negedge clk);
    end
    check("a_stall_20_cycles", bad, 0);
    check("a_stall_rd_bank", int'(bank_a), 0);
    read_a(8, 1);
    release_a();
    check("a_rel_rd_bank", int'(bank_a), 1);
    check("a_rel_ready", int'(rdy_a), 1);
    check("a_rel_frame_ready", int'(frdy_a), 1);
    read_a(3, 1); read_a(4, 0); read_a(783, 1);

    // Mid-frame resync: 300 ones are discarded
    do_reset();
    for (int i = 0; i < 300; i++) send_a(1);
    sync_a = 1'b1; valid_a = 1'b1; bit_a = 1'b1;
    @(negedge clk);
    sync_a = 1'b0; valid_a = 1'b0;
    check("a_sync_drop_pulse", int'(drop_a), 1);
    @(negedge clk);
    check("a_sync_drop_once", int'(drop_a), 0);
    for (int i = 0; i < 784; i++) send_a((i % 5) == 0);
    check("a_sync_frames", int'(frames_a), 1);
    check("a_sync_frame_ready", int'(frdy_a), 1);
    read_a(0, 1); read_a(1, 0); read_a(5, 1); read_a(299, 0); read_a(300, 1); read_a(783, 0);

    // Gappy valid must give the same contents as a gapless stream
    do_reset();
    for (int i = 0; i < 784; i++) begin
      while ($urandom_range(0, 1) == 0) @(negedge clk);
      send_a((i % 8) == 0);
    end
    check("a_gap_frames", int'(frames_a), 1);
    for (int i = 0; i < 784; i++) read_a(i, ((i % 8) == 0) ? 1 : 0);

    // Asynchronous reset in the middle of the second frame
    for (int i = 0; i < 400; i++) send_a(1);
    check("a_pre_rst_frame_ready", int'(frdy_a), 1);
    #2 rst = 1'b1;
    #1;
    check("a_async_rst_frame_ready", int'(frdy_a), 0);
    check("a_async_rst_frames", int'(frames_a), 0);
    check("a_async_rst_ready", int'(rdy_a), 1);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("a_post_rst_frame_ready", int'(frdy_a), 0);

    repeat (2) @(negedge clk);
    check("sb_drained", q_a.size() + q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
